// File: rtl/aes_ecb_ctrl.sv
// -----------------------------------------------------------------------------
// aes_ecb_ctrl
//
// Sequencer between the AES_ECB_ENCRYPT register file and an AES-128 ECB core.
// Software writes the key and the plaintext one 32-bit word at a time. It then
// pulses start. The block checks that all eight words are loaded, launches the
// core with a one-cycle pulse and waits a bounded time for the result. It then
// holds the ciphertext for word-wise readback behind sticky status flags.
//
// Ports
//   clock, reset      rising-edge clock, synchronous active-high reset
//   reg_wr_en/idx/data word write: idx 0-3 key, 4-7 plaintext, word 0/4 = [127:96]
//   start             one-cycle encrypt request
//   done_clr          clears done, err_timeout, err_incomplete
//   rd_idx, rd_data   ciphertext word select (0 = [127:96]), registered read data
//   busy              high from an accepted start until capture or timeout
//   done              sticky result-valid flag
//   err_timeout       sticky: the core did not answer within TIMEOUT_CYCLES
//   err_incomplete    sticky: start arrived with unloaded operand words
//   core_key/block    operands to the core, stable while busy
//   core_start        one-cycle launch pulse to the core
//   core_done/result  core completion pulse and ciphertext
// -----------------------------------------------------------------------------
module aes_ecb_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,  // 2..65535
  parameter int unsigned CNT_W          = 16   // must hold TIMEOUT_CYCLES
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         reg_wr_en,
  input  logic [2:0]   reg_wr_idx,
  input  logic [31:0]  reg_wr_data,
  input  logic         start,
  input  logic         done_clr,
  input  logic [1:0]   rd_idx,
  output logic [31:0]  rd_data,
  output logic         busy,
  output logic         done,
  output logic         err_timeout,
  output logic         err_incomplete,
  output logic [127:0] core_key,
  output logic [127:0] core_block,
  output logic         core_start,
  input  logic         core_done,
  input  logic [127:0] core_result
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  // Counter value in the last cycle the core is allowed to answer in.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t         state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]     key_mask;   // bit w set once key word w has been written
  logic [3:0]     pt_mask;    // bit w set once plaintext word w has been written
  logic [127:0]   result;

  // Operand registers and masks as they will be after this edge's write.
  logic [127:0]   key_nxt;
  logic [127:0]   block_nxt;
  logic [3:0]     key_mask_nxt;
  logic [3:0]     pt_mask_nxt;
  logic           wr_ok;
  logic           operands_ready;

  // Selects one 32-bit word of a 128-bit value; word 0 is the most significant.
  function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[127:96];
      2'd1:    return v[95:64];
      2'd2:    return v[63:32];
      default: return v[31:0];
    endcase
  endfunction

  // Write path. Writes only land in IDLE, so the operands the core sees cannot
  // change between launch and capture. The start check looks at the *_nxt
  // masks so a write in the same cycle as start counts toward completeness.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; without it a
    // path that skips an assignment would infer a latch.
    key_nxt      = core_key;
    block_nxt    = core_block;
    key_mask_nxt = key_mask;
    pt_mask_nxt  = pt_mask;
    wr_ok        = reg_wr_en && (state == ST_IDLE);

    if (wr_ok) begin
      for (int w = 0; w < 4; w++) begin
        if (reg_wr_idx[1:0] == w[1:0]) begin
          if (reg_wr_idx[2]) begin
            block_nxt[(3-w)*32 +: 32] = reg_wr_data;
            pt_mask_nxt[w]            = 1'b1;
          end else begin
            key_nxt[(3-w)*32 +: 32]   = reg_wr_data;
            key_mask_nxt[w]           = 1'b1;
          end
        end
      end
    end

    operands_ready = (&key_mask_nxt) && (&pt_mask_nxt);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the operand and result registers are reset as well. They are
      // only a few hundred flops, and software must read zeros after reset.
      state          <= ST_IDLE;
      cnt            <= '0;
      key_mask       <= '0;
      pt_mask        <= '0;
      result         <= '0;
      core_key       <= '0;
      core_block     <= '0;
      core_start     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_timeout    <= 1'b0;
      err_incomplete <= 1'b0;
      rd_data        <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read in this
      // block sees the pre-edge value. Later assignments to the same register
      // in this block override earlier ones, which sets the priorities below.
      rd_data    <= word_sel(result, rd_idx);
      core_key   <= key_nxt;
      core_block <= block_nxt;
      key_mask   <= key_mask_nxt;
      pt_mask    <= pt_mask_nxt;

      // done_clr is applied first, so a capture or error in the same cycle wins.
      if (done_clr) begin
        done           <= 1'b0;
        err_timeout    <= 1'b0;
        err_incomplete <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (operands_ready) begin
              state      <= ST_LAUNCH;
              busy       <= 1'b1;
              core_start <= 1'b1;
            end else begin
              err_incomplete <= 1'b1;
            end
          end
        end

        ST_LAUNCH: begin
          core_start <= 1'b0;
          cnt        <= '0;
          state      <= ST_WAIT;
        end

        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          // core_done is tested first, so an answer in the last allowed cycle is
          // accepted rather than flagged as a timeout.
          if (core_done) begin
            result  <= core_result;
            done    <= 1'b1;
            pt_mask <= '0;    // each block needs fresh plaintext; the key stays
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          core_start <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ecb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_ecb_ctrl
//
// Self-checking bench for aes_ecb_ctrl. Two instances are built. Instance 0
// uses the default 64-cycle timeout and instance 1 uses an 8-cycle timeout.
// Each instance has its own behavioural core that answers a chosen number of
// cycles after it samples core_start, or never. A software-level model tracks
// which words are loaded, the operands, the sticky flags and the expected
// ciphertext.
// -----------------------------------------------------------------------------
module tb_aes_ecb_ctrl;

  logic         clock = 1'b0;
  logic         reset          [2];
  logic         reg_wr_en      [2];
  logic [2:0]   reg_wr_idx     [2];
  logic [31:0]  reg_wr_data    [2];
  logic         start          [2];
  logic         done_clr       [2];
  logic [1:0]   rd_idx         [2];
  logic [31:0]  rd_data        [2];
  logic         busy           [2];
  logic         done           [2];
  logic         err_timeout    [2];
  logic         err_incomplete [2];
  logic [127:0] core_key       [2];
  logic [127:0] core_block     [2];
  logic         core_start     [2];
  logic         core_done      [2];
  logic [127:0] core_result    [2];

  // Behavioural core settings: latency in cycles after the core samples
  // core_start (-1 = never answers) and the ciphertext it returns.
  int           core_lat       [2];
  logic [127:0] core_val       [2];
  int           starts_seen    [2];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    aes_ecb_ctrl #(
      .TIMEOUT_CYCLES(g == 0 ? 64 : 8),
      .CNT_W         (16)
    ) u_dut (
      .clock         (clock),
      .reset         (reset[g]),
      .reg_wr_en     (reg_wr_en[g]),
      .reg_wr_idx    (reg_wr_idx[g]),
      .reg_wr_data   (reg_wr_data[g]),
      .start         (start[g]),
      .done_clr      (done_clr[g]),
      .rd_idx        (rd_idx[g]),
      .rd_data       (rd_data[g]),
      .busy          (busy[g]),
      .done          (done[g]),
      .err_timeout   (err_timeout[g]),
      .err_incomplete(err_incomplete[g]),
      .core_key      (core_key[g]),
      .core_block    (core_block[g]),
      .core_start    (core_start[g]),
      .core_done     (core_done[g]),
      .core_result   (core_result[g])
    );

    // Core model: it samples core_start on edge N and raises core_done for one
    // cycle so that the controller samples it on edge N + 1 + latency.
    int cd;
    always begin
      core_done[g]   = 1'b0;
      core_result[g] = '0;
      starts_seen[g] = 0;
      cd             = 0;
      forever begin
        @(posedge clock);
        #1;
        core_done[g] = 1'b0;
        if (cd > 0) begin
          cd = cd - 1;
          if (cd == 0) begin
            core_done[g]   = 1'b1;
            core_result[g] = core_val[g];
          end
        end
        if (core_start[g] === 1'b1) begin
          starts_seen[g] = starts_seen[g] + 1;
          if (core_lat[g] >= 0) cd = core_lat[g] + 1;
        end
      end
    end
  end

  // ---------------- reference model (software view) ----------------
  int           sel;
  int           total = 0;
  int           bad   = 0;
  logic [31:0]  m_key [4];
  logic [31:0]  m_pt  [4];
  bit   [3:0]   m_kld;
  bit   [3:0]   m_pld;
  bit           m_busy, m_done, m_to, m_inc;
  logic [127:0] m_res;
  int           m_lat;
  logic [127:0] m_val;

  function automatic int tmo_of(input int g);
    return (g == 0) ? 64 : 8;
  endfunction

  function automatic logic [127:0] key_op();
    return {m_key[0], m_key[1], m_key[2], m_key[3]};
  endfunction

  function automatic logic [127:0] pt_op();
    return {m_pt[0], m_pt[1], m_pt[2], m_pt[3]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_key[i] = '0;
      m_pt[i]  = '0;
    end
    m_kld = '0; m_pld = '0;
    m_busy = 0; m_done = 0; m_to = 0; m_inc = 0;
    m_res = '0;
  endtask

  task automatic model_write(input logic [2:0] idx, input logic [31:0] data);
    if (!m_busy) begin
      if (idx < 3'd4) begin m_key[idx[1:0]] = data; m_kld[idx[1:0]] = 1'b1; end
      else            begin m_pt[idx[1:0]]  = data; m_pld[idx[1:0]] = 1'b1; end
    end
  endtask

  task automatic model_start();
    if (!m_busy) begin
      if (&m_kld && &m_pld) m_busy = 1;
      else                  m_inc  = 1;
    end
  endtask

  task automatic model_clr();
    m_done = 0; m_to = 0; m_inc = 0;
  endtask

  // A run ends with a result when the core answers within the allowed
  // window (latency 0 .. timeout-1), otherwise with a timeout.
  task automatic model_finish();
    if (m_busy) begin
      m_busy = 0;
      if (m_lat >= 0 && m_lat <= tmo_of(sel) - 1) begin
        m_done = 1; m_res = m_val; m_pld = '0;
      end else begin
        m_to = 1;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, {127'b0, obs}, {127'b0, exp});
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    check(tag, {96'b0, obs}, {96'b0, exp});
  endtask

  task automatic write_word(input logic [2:0] idx, input logic [31:0] data);
    reg_wr_en[sel] = 1'b1; reg_wr_idx[sel] = idx; reg_wr_data[sel] = data;
    model_write(idx, data);
    tick();
    reg_wr_en[sel] = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    for (int i = 0; i < 4; i++) write_word(3'(i), k[(3-i)*32 +: 32]);
  endtask

  task automatic load_pt(input logic [127:0] p);
    for (int i = 0; i < 4; i++) write_word(3'(i + 4), p[(3-i)*32 +: 32]);
  endtask

  task automatic arm(input int lat, input logic [127:0] val);
    core_lat[sel] = lat; core_val[sel] = val;
    m_lat = lat; m_val = val;
  endtask

  task automatic pulse_start();
    start[sel] = 1'b1;
    model_start();
    tick();
    start[sel] = 1'b0;
  endtask

  task automatic pulse_clr();
    done_clr[sel] = 1'b1;
    model_clr();
    tick();
    done_clr[sel] = 1'b0;
  endtask

  task automatic do_reset();
    reset[sel] = 1'b1;
    tick(); tick();
    reset[sel] = 1'b0;
    model_reset();
  endtask

  // Waits (bounded) for busy to drop. Counts busy cycles and checks that the
  // operands stayed stable throughout.
  task automatic wait_idle(input string tag, output int nbusy);
    int n, hold_bad;
    n = 0; hold_bad = 0; nbusy = 0;
    while (busy[sel] === 1'b1 && n < 200) begin
      nbusy++;
      if (core_key[sel] !== key_op() || core_block[sel] !== pt_op()) hold_bad++;
      tick();
      n++;
    end
    check_bit({tag, " idle within budget"}, n < 200, 1'b1);
    check_int({tag, " operands held"}, hold_bad, 0);
    model_finish();
  endtask

  task automatic check_flags(input string tag);
    check_bit({tag, " busy"},           busy[sel],           m_busy);
    check_bit({tag, " done"},           done[sel],           m_done);
    check_bit({tag, " err_timeout"},    err_timeout[sel],    m_to);
    check_bit({tag, " err_incomplete"}, err_incomplete[sel], m_inc);
  endtask

  task automatic check_result(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_idx[sel] = 2'(i);
      tick();
      check({tag, $sformatf(" rd_data[%0d]", i)}, {96'b0, rd_data[sel]},
            {96'b0, m_res[(3-i)*32 +: 32]});
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int nbusy, s0;
    logic [127:0] blk;

    for (int g = 0; g < 2; g++) begin
      reset[g] = 1'b1; reg_wr_en[g] = 1'b0; reg_wr_idx[g] = '0; reg_wr_data[g] = '0;
      start[g] = 1'b0; done_clr[g] = 1'b0; rd_idx[g] = '0;
      core_lat[g] = -1; core_val[g] = '0;
    end
    sel = 0;
    model_reset();
    repeat (3) tick();

    // Reset state.
    check({"rst rd_data"}, {96'b0, rd_data[0]}, 128'b0);
    check_flags("rst");
    check_bit("rst core_start", core_start[0], 1'b0);
    check("rst core_key", core_key[0], key_op());
    check("rst core_block", core_block[0], pt_op());
    reset[0] = 1'b0; reset[1] = 1'b0;
    tick();

    // FIPS-197 C.1 run, core answers 10 cycles after sampling core_start.
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    load_pt (128'h00112233445566778899aabbccddeeff);
    check("c1 core_key", core_key[0], key_op());
    check("c1 core_block", core_block[0], pt_op());
    arm(10, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    s0 = starts_seen[0];
    pulse_start();
    wait_idle("c1", nbusy);
    check_int("c1 busy cycles", nbusy, 12);
    check_int("c1 core_start pulses", starts_seen[0] - s0, 1);
    check_flags("c1");
    check_result("c1");
    check("c1 key unchanged", core_key[0], key_op());

    // Incomplete load; then word 7 written in the same cycle as start.
    do_reset();
    load_key(rand128());
    for (int i = 4; i < 7; i++) write_word(3'(i), $urandom);
    s0 = starts_seen[0];
    pulse_start();
    repeat (3) tick();
    check_flags("inc");
    check_int("inc no core_start", starts_seen[0] - s0, 0);
    arm($urandom_range(1, 20), rand128());
    reg_wr_en[0] = 1'b1; reg_wr_idx[0] = 3'd7; reg_wr_data[0] = $urandom;
    start[0] = 1'b1;
    model_write(3'd7, reg_wr_data[0]);
    model_start();
    tick();
    reg_wr_en[0] = 1'b0; start[0] = 1'b0;
    wait_idle("inc run", nbusy);
    check_int("inc run core_start pulses", starts_seen[0] - s0, 1);
    check_flags("inc run");
    check_result("inc run");
    pulse_clr();
    check_flags("inc clr");

    // Writes and start while busy are ignored.
    load_pt(rand128());
    arm(10, rand128());
    s0 = starts_seen[0];
    pulse_start();
    repeat (3) tick();
    blk = pt_op();
    write_word(3'd4, 32'hDEADBEEF);
    pulse_start();
    check("busy core_block", core_block[0], blk);
    wait_idle("busy", nbusy);
    check_int("busy core_start pulses", starts_seen[0] - s0, 1);
    check("busy core_block after", core_block[0], blk);
    check_flags("busy");
    check_result("busy");

    // Key reuse: reload plaintext only.
    load_pt(rand128());
    arm($urandom_range(2, 30), rand128());
    pulse_start();
    check("reuse core_key", core_key[0], key_op());
    wait_idle("reuse", nbusy);
    check_flags("reuse");
    check_result("reuse");

    // done_clr in the same cycle as core_done: capture wins.
    pulse_clr();
    check_bit("coinc done cleared", done[0], 1'b0);
    load_pt(rand128());
    arm(4, rand128());
    pulse_start();
    repeat (5) tick();
    check_bit("coinc done before capture", done[0], 1'b0);
    done_clr[0] = 1'b1;
    model_clr();
    tick();
    done_clr[0] = 1'b0;
    wait_idle("coinc", nbusy);
    check_flags("coinc");
    check_result("coinc");

    // done_clr with an incomplete start in the same cycle: the error wins.
    start[0] = 1'b1; done_clr[0] = 1'b1;
    model_clr();
    model_start();
    tick();
    start[0] = 1'b0; done_clr[0] = 1'b0;
    check_flags("clr vs err");
    pulse_clr();

    // Reset during WAIT; the core answers 2 cycles after reset.
    load_pt(rand128());
    arm(5, rand128());
    pulse_start();
    repeat (3) tick();
    reset[0] = 1'b1;
    tick();
    reset[0] = 1'b0;
    model_reset();
    tick();
    check_flags("rst wait");
    check_bit("rst wait core_start", core_start[0], 1'b0);
    check("rst wait core_key", core_key[0], key_op());
    repeat (4) tick();
    check_flags("rst late done");
    pulse_start();
    check_flags("rst masks cleared");
    pulse_clr();

    // Randomized runs against the model.
    load_key(rand128());
    for (int r = 0; r < 6; r++) begin
      if (r > 0 && $urandom_range(0, 1) == 1) load_key(rand128());
      if ($urandom_range(0, 1) == 1) pulse_clr();
      load_pt(rand128());
      arm($urandom_range(0, 30), rand128());
      pulse_start();
      check($sformatf("rnd%0d core_key", r), core_key[0], key_op());
      wait_idle($sformatf("rnd%0d", r), nbusy);
      check_flags($sformatf("rnd%0d", r));
      check_result($sformatf("rnd%0d", r));
    end

    // Instance with TIMEOUT_CYCLES = 8.
    sel = 1;
    do_reset();
    load_key(rand128());
    load_pt(rand128());
    arm(-1, '0);
    pulse_start();
    check_bit("to core_start", core_start[1], 1'b1);
    repeat (8) tick();
    check_bit("to err one early", err_timeout[1], 1'b0);
    check_bit("to busy one early", busy[1], 1'b1);
    tick();   // 8 cycles after the core sampled core_start
    wait_idle("to", nbusy);
    check_flags("to");
    pulse_clr();
    // Restart without reloading; core answers in the last allowed cycle.
    arm(7, rand128());
    pulse_start();
    wait_idle("to last", nbusy);
    check_flags("to last");
    check_result("to last");
    // One cycle later is a timeout; the late core_done is ignored.
    load_pt(rand128());
    pulse_clr();
    arm(8, rand128());
    pulse_start();
    wait_idle("to over", nbusy);
    check_flags("to over");
    repeat (3) tick();
    check_flags("to over late");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
